// File: rtl/sram_model_pkg.sv
// ============================================================================
// Module      : sram_model_pkg
// Description : Shared helpers for the 1RW/1R SRAM model: lane-width
//               computation, legal read latencies and parameter checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_model_pkg;

    localparam int c_READ_LATENCY_MIN = 1;
    localparam int c_READ_LATENCY_MAX = 2;

    function automatic int lane_width(input int data_width, input int num_wmasks);
        return data_width / num_wmasks;
    endfunction

    function automatic bit lanes_divide(input int data_width, input int num_wmasks);
        return (num_wmasks > 0) && ((data_width % num_wmasks) == 0);
    endfunction

    function automatic bit latency_legal(input int latency);
        return (latency >= c_READ_LATENCY_MIN) && (latency <= c_READ_LATENCY_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_read_pipe.sv
// ============================================================================
// Module      : sram_read_pipe
// Description : LATENCY-deep read-data pipeline with valid and side-flag;
//               output data holds the last completed read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_read_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_flag,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_flag
);

    logic                  w_stg_valid;
    logic [DATA_WIDTH-1:0] w_stg_data;
    logic                  w_stg_flag;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_flag;

    if (LATENCY >= 2) begin : g_extra_stage
        logic                  r_valid;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_flag;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_flag  <= 1'b0;
            end else begin
                r_valid <= i_valid;
                r_flag  <= i_valid & i_flag;
                if (i_valid) begin
                    r_data <= i_data;
                end
            end
        end

        assign w_stg_valid = r_valid;
        assign w_stg_data  = r_data;
        assign w_stg_flag  = r_flag;
    end else begin : g_no_extra_stage
        assign w_stg_valid = i_valid;
        assign w_stg_data  = i_data;
        assign w_stg_flag  = i_flag;
    end

    // Data only moves on a valid beat so the port holds its last read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_flag  <= 1'b0;
        end else begin
            r_out_valid <= w_stg_valid;
            r_out_flag  <= w_stg_valid & w_stg_flag;
            if (w_stg_valid) begin
                r_out_data <= w_stg_data;
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_flag  = r_out_flag;

endmodule

`default_nettype wire

// File: rtl/sram_1rw1r_param.sv
// ============================================================================
// Module      : sram_1rw1r_param
// Description : Dual-port SRAM model, port 0 read/write with byte-lane mask,
//               port 1 read-only, configurable read latency.
//               SRAM_WRITE_BYPASS_EN selects write-first on same-address
//               collision; undefined gives read-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_1rw1r_param
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int NUM_WMASKS   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1,
    output logic                  collision
);

    localparam int                  c_LANE_W = lane_width(DATA_WIDTH, NUM_WMASKS);
    localparam int                  c_IDX_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    if (!lanes_divide(DATA_WIDTH, NUM_WMASKS)) begin : g_bad_lanes
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of NUM_WMASKS");
    end
    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic                  w_in_range0;
    logic                  w_in_range1;
    logic [c_IDX_W-1:0]    w_idx0;
    logic [c_IDX_W-1:0]    w_idx1;
    logic                  w_wr_en;
    logic                  w_rd0_en;
    logic                  w_rd1_en;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_word0;
    logic [DATA_WIDTH-1:0] w_word1;
    logic [DATA_WIDTH-1:0] w_rd1_data;
    logic                  w_unused_flag0;

    assign w_in_range0 = {1'b0, addr0} < c_DEPTH;
    assign w_in_range1 = {1'b0, addr1} < c_DEPTH;
    assign w_idx0      = addr0[c_IDX_W-1:0];
    assign w_idx1      = addr1[c_IDX_W-1:0];

    // No access is accepted while reset is held.
    assign w_wr_en   = !rst && !csb0 && !web0 && w_in_range0;
    assign w_rd0_en  = !rst && !csb0 && web0;
    assign w_rd1_en  = !rst && !csb1;
    assign w_collide = w_rd1_en && w_wr_en && w_in_range1 && (addr0 == addr1);

    assign w_word0 = w_in_range0 ? r_mem[w_idx0] : '0;
    assign w_word1 = w_in_range1 ? r_mem[w_idx1] : '0;

`ifdef SRAM_WRITE_BYPASS_EN
    logic [DATA_WIDTH-1:0] w_merged;

    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane_merge
        assign w_merged[g*c_LANE_W +: c_LANE_W] = wmask0[g] ? din0[g*c_LANE_W +: c_LANE_W]
                                                            : w_word1[g*c_LANE_W +: c_LANE_W];
    end

    assign w_rd1_data = w_collide ? w_merged : w_word1;
`else
    // Array read happens before the write lands, so port 1 sees old data.
    assign w_rd1_data = w_word1;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    r_mem[w_idx0][i*c_LANE_W +: c_LANE_W] <= din0[i*c_LANE_W +: c_LANE_W];
                end
            end
        end
    end

    sram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_pipe0 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd0_en),
        .i_data  (w_word0),
        .i_flag  (1'b0),
        .o_valid (rvalid0),
        .o_data  (dout0),
        .o_flag  (w_unused_flag0)
    );

    sram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_pipe1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd1_en),
        .i_data  (w_rd1_data),
        .i_flag  (w_collide),
        .o_valid (rvalid1),
        .o_data  (dout1),
        .o_flag  (collision)
    );

endmodule

`default_nettype wire
